// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder: samples an_in/seg_in from a multiplexed 7-seg driver, decodes each digit, emits digits_out/frame_valid/seg_err/anode_err/stale
module seven_segment_scan_decoder #(
  parameter int NUM_DIGITS     = 8,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2**21
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              seg_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic                    frame_valid,
  output logic                    seg_err,
  output logic                    anode_err,
  output logic                    stale
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;
  state_t                  state;
  logic [NUM_DIGITS-1:0]   s_an, mask;
  logic [6:0]              s_seg;
  logic [CW-1:0]           stab_cnt;
  logic [TW-1:0]           tcnt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [3:0]              nib;
  logic [IW-1:0]           idx;
  logic                    settled, all_high, one_low, frame_done;
  always_comb begin
    nib = 4'hE;
    case (s_seg)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b1111111: nib = 4'hF;
      default:    nib = 4'hE;
    endcase
  end
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (!s_an[i]) idx = IW'(i);
  end
  assign settled    = stab_cnt == CW'(STABLE_CYCLES - 1);
  assign all_high   = &s_an;
  assign one_low    = $onehot(~s_an);
  assign frame_done = &mask;
  assign stale      = tcnt == TW'(TIMEOUT_CYCLES);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      s_an        <= '1;
      s_seg       <= '1;
      stab_cnt    <= '0;
      mask        <= '0;
      shadow      <= '1;
      digits_out  <= '1;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
      tcnt        <= TW'(TIMEOUT_CYCLES);
    end else begin
      s_an        <= an_in;
      s_seg       <= seg_in;
      stab_cnt    <= {an_in, seg_in} != {s_an, s_seg} ? '0 : settled ? stab_cnt : stab_cnt + 1'b1;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
      frame_valid <= frame_done;
      tcnt        <= frame_done ? '0 : stale ? tcnt : tcnt + 1'b1;
      if (frame_done) begin
        digits_out <= shadow;
        mask       <= '0;
      end
      case (state)
        IDLE: if (!all_high) state <= SETTLE;
        SETTLE: if (settled) begin
          if (all_high) state <= IDLE;
          else begin
            state <= CAPTURED;
            if (one_low) begin
              shadow[4*idx +: 4] <= nib;
              mask[idx]          <= 1'b1;
              seg_err            <= nib == 4'hE;
            end else anode_err <= 1'b1;
          end
        end
        CAPTURED: if (stab_cnt == '0) state <= SETTLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
